// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: upstream/downstream handshake bundle for imm_gen_pipe.
// The master modport belongs to whoever drives instructions in and
// drains immediates out; the slave modport belongs to the generator.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    // Upstream side: instruction in.
    logic            valid_i;
    logic            ready_o;
    logic [31:0]     instr_i;
    logic [2:0]      immsrc_i;

    // Downstream side: immediate out.
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] immop_o;
    logic            illegal_o;

    modport master (
        output valid_i, instr_i, immsrc_i, ready_i,
        input  ready_o, valid_o, immop_o, illegal_o
    );

    modport slave (
        input  valid_i, instr_i, immsrc_i, ready_i,
        output ready_o, valid_o, immop_o, illegal_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator for RV32/RV64.
// The instruction is decoded combinationally, and the {immediate, illegal}
// pair is buffered in a 2-entry FIFO behind a valid/ready handshake.
// Build option: define IMMGEN_BYPASS_EN to let a result skip the empty FIFO
// and appear on the outputs in the same cycle it is offered (latency 0).
// XLEN must be 32 or 64.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input logic         clk_i,
    input logic         rst_ni,
    imm_gen_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ZIMM  = 3'b110,
        IMM_RSVD  = 3'b111
    } imm_src_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    logic [31:0]     instr;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_dec;
    logic            illegal_dec;
    logic            instr_unused;

    entry_t          mem_q [2];
    entry_t          mem_d [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;

    logic            fifo_valid;
    logic            fifo_ready;
    logic            bypass;
    logic            push;
    logic            pop;
    entry_t          head;

    assign instr        = bus.instr_i;
    // The opcode field carries no immediate bits.
    assign instr_unused = ^instr[6:0];

    // Decode the selected format into a 32-bit value whose bit 31 is the
    // extension bit for the upper half when XLEN is 64.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which would infer a latch).
        imm32       = '0;
        illegal_dec = 1'b0;
        case (imm_src_e'(bus.immsrc_i))
            IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            IMM_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            IMM_U:     imm32 = {instr[31:12], 12'b0};
            // RV64 shift amounts are 6 bits wide, RV32 ones 5 bits.
            IMM_SHAMT: imm32 = {26'b0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
            IMM_ZIMM:  imm32 = {27'b0, instr[19:15]};
            IMM_RSVD:  illegal_dec = 1'b1;
        endcase
    end

    // Widen to XLEN; zero-extended formats have bit 31 clear, so copying it
    // is correct for every format.
    if (XLEN == 64) begin : g_xlen64
        assign imm_dec = {{32{imm32[31]}}, imm32};
    end else begin : g_xlen32
        assign imm_dec = imm32;
    end

    assign fifo_valid = (count_q != 2'd0);
    assign fifo_ready = (count_q != 2'd2);
    assign head       = mem_q[rd_ptr_q];

`ifdef IMMGEN_BYPASS_EN
    // An empty buffer with both sides ready hands the item straight through.
    assign bypass = !fifo_valid && bus.valid_i && bus.ready_i;
`else
    assign bypass = 1'b0;
`endif

    // A full buffer refuses pushes even if the head pops this cycle.
    assign push = bus.valid_i && fifo_ready && !bypass;
    assign pop  = fifo_valid && bus.ready_i;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{imm: imm_dec, illegal: illegal_dec};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            // NOTE: the two storage entries are cleared on reset as well, so
            // no stale immediate survives a reset inside the buffer.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Output mux: bypassed result, buffer head, or zeros when idle.
    always_comb begin
        bus.valid_o   = fifo_valid;
        bus.immop_o   = '0;
        bus.illegal_o = 1'b0;
        if (bypass) begin
            bus.valid_o   = 1'b1;
            bus.immop_o   = imm_dec;
            bus.illegal_o = illegal_dec;
        end else if (fifo_valid) begin
            bus.immop_o   = head.imm;
            bus.illegal_o = head.illegal;
        end
    end

    assign bus.ready_o = fifo_ready;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance with identical
// stimulus and checks both against a queue-based model of the generator,
// plus hand-computed immediates for the documented example instructions.
module tb_imm_gen_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [31:0] instr_i = '0;
    logic [2:0]  immsrc_i = '0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic        ill;
    } exp_t;

    exp_t q[$];

    always #5 clk_i = ~clk_i;

    imm_gen_pipe_if #(.XLEN(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64)) if64 ();

    assign if32.valid_i  = valid_i;
    assign if32.ready_i  = ready_i;
    assign if32.instr_i  = instr_i;
    assign if32.immsrc_i = immsrc_i;
    assign if64.valid_i  = valid_i;
    assign if64.ready_i  = ready_i;
    assign if64.instr_i  = instr_i;
    assign if64.immsrc_i = immsrc_i;

    imm_gen_pipe #(.XLEN(32)) dut32 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if32));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if64));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Immediate value from the format rules, as two's-complement arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input bit x64);
        longint v;
        v = 0;
        case (src)
            3'd0: begin
                v = longint'(ins[31:20]);
                if (ins[31]) v = v - (longint'(1) << 12);
            end
            3'd1: begin
                v = longint'({ins[31:25], ins[11:7]});
                if (ins[31]) v = v - (longint'(1) << 12);
            end
            3'd2: begin
                v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
                if (ins[31]) v = v - (longint'(1) << 13);
            end
            3'd3: begin
                v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
                if (ins[31]) v = v - (longint'(1) << 21);
            end
            3'd4: begin
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v = v - (longint'(1) << 32);
            end
            3'd5:    v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd6:    v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        return x64 ? 64'(v) : (64'(v) & 64'h0000_0000_FFFF_FFFF);
    endfunction

    function automatic exp_t ref_entry(input logic [31:0] ins, input logic [2:0] src);
        exp_t e;
        logic [63:0] lo;
        e.imm64 = ref_imm(ins, src, 1'b1);
        lo      = ref_imm(ins, src, 1'b0);
        e.imm32 = lo[31:0];
        e.ill   = (src == 3'd7);
        return e;
    endfunction

    function automatic bit model_bypass();
`ifdef IMMGEN_BYPASS_EN
        return (q.size() == 0) && valid_i && ready_i && rst_ni;
`else
        return 1'b0;
`endif
    endfunction

    // Model state: a queue of at most two pending results.
    initial begin
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                q.delete();
            end else begin
                bit acc, pop, byp;
                byp = model_bypass();
                acc = valid_i && (q.size() != 2);
                pop = ready_i && (q.size() != 0 || byp);
                if (!byp) begin
                    if (pop) void'(q.pop_front());
                    if (acc) q.push_back(ref_entry(instr_i, immsrc_i));
                end
            end
        end
    end

    // Every falling edge: both instances must match the model exactly.
    initial begin
        forever begin
            @(negedge clk_i);
            begin
                exp_t e;
                bit   ev;
                e  = '{imm64: '0, imm32: '0, ill: 1'b0};
                ev = 1'b0;
                if (model_bypass()) begin
                    e  = ref_entry(instr_i, immsrc_i);
                    ev = 1'b1;
                end else if (q.size() != 0) begin
                    e  = q[0];
                    ev = 1'b1;
                end
                check("valid_o32", 64'(if32.valid_o), 64'(ev));
                check("valid_o64", 64'(if64.valid_o), 64'(ev));
                check("ready_o32", 64'(if32.ready_o), 64'(q.size() != 2));
                check("ready_o64", 64'(if64.ready_o), 64'(q.size() != 2));
                check("immop_o32", 64'(if32.immop_o), 64'(e.imm32));
                check("immop_o64", if64.immop_o, e.imm64);
                check("illegal_o32", 64'(if32.illegal_o), 64'(e.ill));
                check("illegal_o64", 64'(if64.illegal_o), 64'(e.ill));
            end
        end
    end

    // One item with ready_i high, starting and ending 1 time unit after an edge.
    task automatic send(input logic [31:0] ins, input logic [2:0] src,
                        input logic [31:0] e32, input logic [63:0] e64, input logic eill);
        valid_i  = 1'b1;
        ready_i  = 1'b1;
        instr_i  = ins;
        immsrc_i = src;
`ifdef IMMGEN_BYPASS_EN
        #2;
        check("lit_imm32", 64'(if32.immop_o), 64'(e32));
        check("lit_imm64", if64.immop_o, e64);
        check("lit_ill", 64'(if32.illegal_o), 64'(eill));
        @(posedge clk_i); #1;
        valid_i = 1'b0;
`else
        #2;
        check("lit_pre_valid", 64'(if32.valid_o), 64'd0);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        check("lit_valid", 64'(if32.valid_o), 64'd1);
        check("lit_imm32", 64'(if32.immop_o), 64'(e32));
        check("lit_imm64", if64.immop_o, e64);
        check("lit_ill", 64'(if32.illegal_o), 64'(eill));
`endif
        @(posedge clk_i); #1;
    endtask

    initial begin
        #12;
        check("rst_valid", 64'(if32.valid_o), 64'd0);
        check("rst_ready", 64'(if64.ready_o), 64'd1);
        @(posedge clk_i); #2;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Documented example immediates.
        send(32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send(32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(32'hFE000CE3, 3'd2, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        send(32'hFFDFF0EF, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(32'h800002B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send(32'h123452B7, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0);
        send(32'h0002D073, 3'd6, 32'h00000005, 64'h0000000000000005, 1'b0);
        send(32'h03F0D093, 3'd5, 32'h0000001F, 64'h000000000000003F, 1'b0);
        send(32'hDEADBEEF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1);
        send(32'h00100093, 3'd0, 32'h00000001, 64'h0000000000000001, 1'b0);

        // Back-pressure: three items offered, two taken, head held stable.
        ready_i = 1'b0; valid_i = 1'b1; immsrc_i = 3'd0;
        instr_i = 32'h00100093;
        @(posedge clk_i); #1;
        instr_i = 32'h00200093;
        @(posedge clk_i); #1;
        instr_i = 32'h00300093;
        check("bp_ready_low", 64'(if32.ready_o), 64'd0);
        check("bp_head", 64'(if32.immop_o), 64'd1);
        @(posedge clk_i); #1;
        check("bp_head_stable", if64.immop_o, 64'd1);
        check("bp_still_full", 64'(if64.ready_o), 64'd0);
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("bp_pop1", 64'(if32.immop_o), 64'd2);
        check("bp_ready_up", 64'(if32.ready_o), 64'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        check("bp_third", 64'(if32.immop_o), 64'd3);
        @(posedge clk_i); #1;
        check("bp_drained", 64'(if32.valid_o), 64'd0);

        // Asynchronous reset with two entries buffered.
        ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h7FF00093; immsrc_i = 3'd0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        check("ar_full", 64'(if64.ready_o), 64'd0);
        #2 rst_ni = 1'b0;
        #1;
        check("ar_valid", 64'(if32.valid_o), 64'd0);
        check("ar_ready", 64'(if64.ready_o), 64'd1);
        check("ar_imm", if64.immop_o, 64'd0);
        check("ar_ill", 64'(if32.illegal_o), 64'd0);
        @(posedge clk_i); #2;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        send(32'h80000093, 3'd0, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                valid_i = 1'b0;
                #2 rst_ni = 1'b0;
                @(posedge clk_i); #2;
                rst_ni = 1'b1;
                @(posedge clk_i); #1;
            end else begin
                valid_i  = ($urandom_range(0, 3) != 0);
                ready_i  = ($urandom_range(0, 2) != 0);
                instr_i  = $urandom;
                immsrc_i = 3'($urandom_range(0, 7));
                @(posedge clk_i); #1;
            end
        end

        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
